// File: rtl/ccff_chain_loader.sv
// Drives the head of a tile's CCFF configuration chain. Bitstream words are shifted in MSB-first.
// An optional rotate pass then restores the chain and checks its parity against the loaded bits.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 36,
    parameter int WORD_W    = 8,
    parameter int VERIFY_EN = 1
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              prog_clk_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WORD_W-1:0] shreg_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [CNT_W-1:0]  vcnt_r;
    logic [IDX_W-1:0]  bit_idx_r;
    logic              load_par_r;
    logic              rd_par_r;
    logic              cfg_err_r;
    logic              done_r;
    logic              bs_ready_r;
    logic              prog_clk_en_r;
    logic              busy_r;
    logic              ccff_head_s;
    logic              take_word_s;

    function automatic logic par_step(input logic par, input logic bit_in);
        return par ^ bit_in;
    endfunction

    assign take_word_s = bs_valid & bs_ready_r;

    // Next-state decode for the load/verify sequencer
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_FETCH;
                else       state_nxt_s = ST_IDLE;
            end
            ST_FETCH: begin
                if (take_word_s) state_nxt_s = ST_SHIFT;
                else             state_nxt_s = ST_FETCH;
            end
            ST_SHIFT: begin
                // Chain full wins over end-of-word; leftover bits of the last word are dropped
                if (bit_cnt_r == LAST_CNT) begin
                    if (VERIFY_EN != 0) state_nxt_s = ST_VERIFY;
                    else                state_nxt_s = ST_DONE;
                end else if (bit_idx_r == LAST_IDX) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_VERIFY: begin
                if (vcnt_r == LAST_CNT) state_nxt_s = ST_DONE;
                else                    state_nxt_s = ST_VERIFY;
            end
            ST_DONE: begin
                if (start) state_nxt_s = ST_FETCH;
                else       state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Chain head select: tail loops back while verifying, shift register MSB while loading
    always_comb begin
        ccff_head_s = 1'b0;
        if (state_r == ST_VERIFY) begin
            ccff_head_s = ccff_tail;
        end else if (state_r == ST_SHIFT) begin
            ccff_head_s = shreg_r[WORD_W-1];
        end else begin
            ccff_head_s = 1'b0;
        end
    end

    // State, datapath and registered status outputs
    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            state_r       <= ST_IDLE;
            shreg_r       <= {WORD_W{1'b0}};
            bit_cnt_r     <= {CNT_W{1'b0}};
            vcnt_r        <= {CNT_W{1'b0}};
            bit_idx_r     <= {IDX_W{1'b0}};
            load_par_r    <= 1'b0;
            rd_par_r      <= 1'b0;
            cfg_err_r     <= 1'b0;
            done_r        <= 1'b0;
            bs_ready_r    <= 1'b0;
            prog_clk_en_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            bs_ready_r    <= (state_nxt_s == ST_FETCH);
            prog_clk_en_r <= (state_nxt_s == ST_SHIFT) || (state_nxt_s == ST_VERIFY);
            busy_r        <= (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_SHIFT) ||
                             (state_nxt_s == ST_VERIFY);
            done_r        <= (state_nxt_s == ST_DONE);
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        bit_cnt_r  <= {CNT_W{1'b0}};
                        vcnt_r     <= {CNT_W{1'b0}};
                        bit_idx_r  <= {IDX_W{1'b0}};
                        load_par_r <= 1'b0;
                        rd_par_r   <= 1'b0;
                        cfg_err_r  <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (take_word_s) begin
                        shreg_r   <= bs_data;
                        bit_idx_r <= {IDX_W{1'b0}};
                    end
                end
                ST_SHIFT: begin
                    shreg_r    <= {shreg_r[WORD_W-2:0], 1'b0};
                    load_par_r <= par_step(load_par_r, shreg_r[WORD_W-1]);
                    bit_cnt_r  <= bit_cnt_r + CNT_W'(1);
                    bit_idx_r  <= bit_idx_r + IDX_W'(1);
                    if (bit_cnt_r == LAST_CNT) vcnt_r <= {CNT_W{1'b0}};
                end
                ST_VERIFY: begin
                    rd_par_r <= par_step(rd_par_r, ccff_tail);
                    vcnt_r   <= vcnt_r + CNT_W'(1);
                    if (vcnt_r == LAST_CNT) begin
                        cfg_err_r <= (par_step(rd_par_r, ccff_tail) != load_par_r);
                    end
                end
                default: begin
                    shreg_r <= shreg_r;
                end
            endcase
        end
    end

    assign bs_ready    = bs_ready_r;
    assign prog_clk_en = prog_clk_en_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign cfg_err     = cfg_err_r;
    assign ccff_head   = ccff_head_s;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: models the downstream chain as a CHAIN_LEN-bit shift register.
// Expected head streams, chain contents and parity error come from the words themselves.
module tb_ccff_chain_loader;

    localparam int L  = 36;
    localparam int W  = 8;
    localparam int NW = (L + W - 1) / W;
    localparam int FLIP_POS = 17;
    localparam logic [L-1:0] FLIP_MASK = L'(1) << FLIP_POS;

    logic         prog_clk = 1'b0;
    logic         pReset   = 1'b0;
    logic         start    = 1'b0;
    logic [W-1:0] bs_data  = 8'h00;
    logic         bs_valid = 1'b0;
    logic         bs_ready, ccff_head, prog_clk_en, ccff_tail, busy, done, cfg_err;

    logic [L-1:0] chain = {L{1'b0}};
    int           en_cnt = 0;
    int           hs_cnt = 0;
    bit           head_q[$];
    bit           inject_en = 1'b0;
    int           inject_at = 0;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] t2w[NW];
    int           no_gap[NW];

    assign ccff_tail = chain[L-1];

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W), .VERIFY_EN(1)) dut (
        .prog_clk   (prog_clk),
        .pReset     (pReset),
        .start      (start),
        .bs_data    (bs_data),
        .bs_valid   (bs_valid),
        .bs_ready   (bs_ready),
        .ccff_head  (ccff_head),
        .prog_clk_en(prog_clk_en),
        .ccff_tail  (ccff_tail),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    // Downstream chain, with optional single-bit corruption right after the load completes
    always @(posedge prog_clk) begin
        if (bs_valid && bs_ready) hs_cnt <= hs_cnt + 1;
        if (prog_clk_en) begin
            head_q.push_back(ccff_head);
            en_cnt <= en_cnt + 1;
            chain  <= {chain[L-2:0], ccff_head} ^
                      ((inject_en && (en_cnt + 1 == inject_at)) ? FLIP_MASK : {L{1'b0}});
        end
    end

    task automatic run_load(input logic [W-1:0] w[NW], input int gap[NW], input bit flip,
                            input bit start_mid, input string tag);
        int           en_base, hs_base, hq_base, cyc;
        bit           pulsed;
        logic [W-1:0] t;
        logic [L-1:0] exp_ld, exp_vrf, got_ld, got_vrf;
        pulsed = 1'b0;
        for (int i = 0; i < L; i++) begin
            t = w[i / W];
            exp_ld[L-1-i] = t[W-1-(i % W)];
        end
        exp_vrf   = flip ? (exp_ld ^ FLIP_MASK) : exp_ld;
        en_base   = en_cnt;
        hs_base   = hs_cnt;
        hq_base   = head_q.size();
        inject_at = en_base + L;
        inject_en = flip;

        @(negedge prog_clk);
        start    = 1'b1;
        bs_data  = w[0];
        bs_valid = (gap[0] == 0);
        @(negedge prog_clk);
        start = 1'b0;
        checks++;
        if (bs_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0)
            $display("FAIL %s start_to_fetch: ready/busy/done=%b%b%b expected 110",
                     tag, bs_ready, busy, done);
        if (bs_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) errors++;

        for (int i = 0; i < NW; i++) begin
            bs_data  = w[i];
            bs_valid = (gap[i] == 0);
            cyc = 0;
            while (bs_ready !== 1'b1 && cyc < 100) begin
                if (start_mid && i == 2 && !pulsed) begin
                    start  = 1'b1;
                    pulsed = 1'b1;
                end
                @(negedge prog_clk);
                start = 1'b0;
                cyc++;
            end
            checks++;
            if (bs_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s ready_timeout word %0d: bs_ready=%b expected 1", tag, i, bs_ready);
                bs_valid  = 1'b0;
                inject_en = 1'b0;
                return;
            end
            for (int g = 0; g < gap[i]; g++) begin
                checks++;
                if (prog_clk_en !== 1'b0 || bs_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s gap_frozen: en/ready=%b%b expected 01", tag, prog_clk_en, bs_ready);
                end
                @(negedge prog_clk);
            end
            bs_valid = 1'b1;
            @(negedge prog_clk);
        end
        bs_valid = 1'b0;

        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge prog_clk);
            cyc++;
        end
        inject_en = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout: done=%b expected 1", tag, done);
            return;
        end
        checks++;
        if (hs_cnt - hs_base != NW) begin
            errors++;
            $display("FAIL %s handshakes: got %0d expected %0d", tag, hs_cnt - hs_base, NW);
        end
        checks++;
        if (head_q.size() - hq_base != 2 * L) begin
            errors++;
            $display("FAIL %s enable_cycles: got %0d expected %0d", tag, head_q.size() - hq_base, 2 * L);
            return;
        end
        for (int k = 0; k < L; k++) begin
            got_ld[L-1-k]  = head_q[hq_base + k];
            got_vrf[L-1-k] = head_q[hq_base + L + k];
        end
        checks++;
        if (got_ld !== exp_ld) begin
            errors++;
            $display("FAIL %s load_stream: got %h expected %h", tag, got_ld, exp_ld);
        end
        checks++;
        if (got_vrf !== exp_vrf) begin
            errors++;
            $display("FAIL %s verify_stream: got %h expected %h", tag, got_vrf, exp_vrf);
        end
        checks++;
        if (chain !== exp_vrf) begin
            errors++;
            $display("FAIL %s chain: got %h expected %h", tag, chain, exp_vrf);
        end
        checks++;
        if (cfg_err !== flip) begin
            errors++;
            $display("FAIL %s cfg_err: got %b expected %b", tag, cfg_err, flip);
        end
    endtask

    task automatic test_reset();
        pReset = 1'b0;
        repeat (2) @(negedge prog_clk);
        checks++;
        if ({bs_ready, prog_clk_en, ccff_head, busy, done, cfg_err} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {bs_ready, prog_clk_en, ccff_head, busy, done, cfg_err});
        end
        pReset = 1'b1;
        @(negedge prog_clk);
    endtask

    task automatic test_load_basic();
        run_load(t2w, no_gap, 1'b0, 1'b0, "basic");
    endtask

    task automatic test_valid_gap();
        int gp[NW];
        gp = '{0, 0, 3, 0, 0};
        run_load(t2w, gp, 1'b0, 1'b0, "gap");
    endtask

    task automatic test_verify_flip();
        run_load(t2w, no_gap, 1'b1, 1'b0, "flip");
    endtask

    task automatic test_reset_mid_load();
        int base, cyc;
        base = en_cnt;
        @(negedge prog_clk);
        start    = 1'b1;
        bs_valid = 1'b1;
        bs_data  = W'($urandom);
        @(negedge prog_clk);
        start = 1'b0;
        cyc = 0;
        while ((en_cnt - base) < 20 && cyc < 100) begin
            @(negedge prog_clk);
            cyc++;
        end
        pReset = 1'b0;
        @(negedge prog_clk);
        checks++;
        if ({prog_clk_en, busy, bs_ready, done} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset: en/busy/ready/done=%b expected 0000",
                     {prog_clk_en, busy, bs_ready, done});
        end
        pReset   = 1'b1;
        bs_valid = 1'b0;
        @(negedge prog_clk);
        run_load(t2w, no_gap, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_start_while_busy();
        run_load(t2w, no_gap, 1'b0, 1'b1, "start_mid");
    endtask

    task automatic test_done_hold_restart();
        int hs_base;
        hs_base  = hs_cnt;
        bs_valid = 1'b1;
        repeat (3) @(negedge prog_clk);
        checks++;
        if (done !== 1'b1 || prog_clk_en !== 1'b0 || bs_ready !== 1'b0 || hs_cnt != hs_base) begin
            errors++;
            $display("FAIL done_hold: done/en/ready=%b%b%b hs=%0d expected 100 hs=0",
                     done, prog_clk_en, bs_ready, hs_cnt - hs_base);
        end
        bs_valid = 1'b0;
        run_load(t2w, no_gap, 1'b0, 1'b0, "restart");
    endtask

    task automatic test_random();
        logic [W-1:0] rw[NW];
        int           rg[NW];
        bit           rf;
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < NW; k++) begin
                rw[k] = W'($urandom);
                rg[k] = $urandom_range(0, 3);
            end
            rf = 1'($urandom_range(0, 1));
            run_load(rw, rg, rf, 1'b0, $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        t2w    = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h90};
        no_gap = '{0, 0, 0, 0, 0};
        test_reset();
        test_load_basic();
        test_valid_gap();
        test_verify_flip();
        test_reset_mid_load();
        test_start_while_busy();
        test_done_hold_restart();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
